// File: rtl/interrupt_ack_sequencer_8259a_pkg.sv
// ---------------------------------------------------------------------------
// pic_8259a_pkg
// Shared types and helpers for the 8259A interrupt acknowledge sequencer.
//   - ack_state_e        : acknowledge FSM states
//   - lowest_bit_t       : result of a lowest-set-bit search (valid + index)
//   - lowestSetBit       : lowest set bit of a level vector (IR0 = highest)
//   - higherPriorityMask : one-hot-per-level mask of levels strictly above
//                          the given in-service level (all levels if none)
// No ports (package).
// ---------------------------------------------------------------------------
package pic_8259a_pkg;

  localparam int IRQ_LEVELS = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQUEST = 3'd1,
    ACK1    = 3'd2,
    WAIT2   = 3'd3,
    ACK2    = 3'd4
  } ack_state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] index;
  } lowest_bit_t;

  // Scans from the top down so the last hit is the lowest index, which is
  // the highest priority level in fully nested mode.
  function automatic lowest_bit_t lowestSetBit(input logic [IRQ_LEVELS-1:0] bits);
    lowest_bit_t result;
    result.valid = 1'b0;
    result.index = 3'd0;
    for (int i = IRQ_LEVELS - 1; i >= 0; i--) begin
      if (bits[i]) begin
        result.valid = 1'b1;
        result.index = 3'(i);
      end
    end
    return result;
  endfunction

  // With nothing in service every level may interrupt; otherwise only the
  // levels with a smaller index than the in-service level may.
  function automatic logic [IRQ_LEVELS-1:0] higherPriorityMask(input lowest_bit_t inService);
    logic [IRQ_LEVELS-1:0] mask;
    mask = '0;
    for (int i = 0; i < IRQ_LEVELS; i++) begin
      if (!inService.valid || (i < int'(inService.index))) begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_8259a_if.sv
// ---------------------------------------------------------------------------
// interrupt_ack_sequencer_8259a_if
// Bus bundle between the request register / CPU side (master) and the
// acknowledge sequencer (slave).
//   interrupt_request_register  IRR from the request block, bit0 = IR0
//   interrupt_mask              1 = level masked
//   vector_base                 T7..T3 from ICW2
//   interrupt_acknowledge_n     INTA#, already synchronous to clock
//   end_of_interrupt            one-cycle non-specific EOI pulse
//   interrupt_to_cpu            INT
//   freeze                      holds the request register during acknowledge
//   clear_interrupt_request     one-hot, one-cycle IRR clear pulse
//   in_service_register         ISR
//   data_out / data_out_enable  vector byte and its drive enable
// ---------------------------------------------------------------------------
interface interrupt_ack_sequencer_8259a_if;
  import pic_8259a_pkg::*;

  logic [IRQ_LEVELS-1:0] interrupt_request_register;
  logic [IRQ_LEVELS-1:0] interrupt_mask;
  logic [4:0]            vector_base;
  logic                  interrupt_acknowledge_n;
  logic                  end_of_interrupt;
  logic                  interrupt_to_cpu;
  logic                  freeze;
  logic [IRQ_LEVELS-1:0] clear_interrupt_request;
  logic [IRQ_LEVELS-1:0] in_service_register;
  logic [7:0]            data_out;
  logic                  data_out_enable;

  modport master (
    output interrupt_request_register, interrupt_mask, vector_base,
           interrupt_acknowledge_n, end_of_interrupt,
    input  interrupt_to_cpu, freeze, clear_interrupt_request,
           in_service_register, data_out, data_out_enable
  );

  modport slave (
    input  interrupt_request_register, interrupt_mask, vector_base,
           interrupt_acknowledge_n, end_of_interrupt,
    output interrupt_to_cpu, freeze, clear_interrupt_request,
           in_service_register, data_out, data_out_enable
  );

endinterface

// File: rtl/interrupt_ack_sequencer_8259a_resolver.sv
// ---------------------------------------------------------------------------
// priority_resolver_8259a
// Combinational fixed-priority, fully nested resolver.
//   request_i     levels requesting service
//   mask_i        1 = level masked
//   in_service_i  levels currently in service (limits nesting)
//   winner_o      lowest-index eligible level
//   valid_o       1 when some level is eligible
// With mask_i and in_service_i tied to 0 it simply finds the highest
// priority set bit of request_i.
// ---------------------------------------------------------------------------
module priority_resolver_8259a
  import pic_8259a_pkg::*;
(
  input  logic [IRQ_LEVELS-1:0] request_i,
  input  logic [IRQ_LEVELS-1:0] mask_i,
  input  logic [IRQ_LEVELS-1:0] in_service_i,
  output logic [2:0]            winner_o,
  output logic                  valid_o
);

  lowest_bit_t           highestInService;
  lowest_bit_t           winner;
  logic [IRQ_LEVELS-1:0] eligible;

  // A request is eligible only if unmasked and strictly above the highest
  // level already in service.
  always_comb begin
    highestInService = lowestSetBit(in_service_i);
    eligible         = request_i & ~mask_i & higherPriorityMask(highestInService);
    winner           = lowestSetBit(eligible);
  end

  assign winner_o = winner.index;
  assign valid_o  = winner.valid;

endmodule

// File: rtl/interrupt_ack_sequencer_8259a.sv
// ---------------------------------------------------------------------------
// interrupt_ack_sequencer_8259a
// Consumer side of the 8259A request register: resolves priority, raises
// INT, runs the 8086-mode two-pulse INTA handshake, maintains the ISR,
// pulses the IRR clear, freezes the IRR during acknowledge and drives the
// vector byte during the second INTA pulse.
// Ports:
//   clock   system clock
//   reset   asynchronous, active-high reset
//   bus     interrupt_ack_sequencer_8259a_if.slave (see interface header)
// Parameter:
//   SPURIOUS_LEVEL  level reported when nothing is eligible at the first
//                   INTA falling edge
// Build option:
//   AUTO_EOI_EN  when defined, the ISR bit set by an acknowledge is cleared
//                on the second INTA rising edge; otherwise ISR bits clear
//                only through end_of_interrupt.
// ---------------------------------------------------------------------------
module interrupt_ack_sequencer_8259a
  import pic_8259a_pkg::*;
#(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input logic                            clock,
  input logic                            reset,
  interrupt_ack_sequencer_8259a_if.slave bus
);

`ifdef AUTO_EOI_EN
  localparam bit AutoEoi = 1'b1;
`else
  localparam bit AutoEoi = 1'b0;
`endif

  ack_state_e            state_q, state_d;
  logic                  intaN_q;
  logic [2:0]            level_q, level_d;
  logic                  spurious_q, spurious_d;
  logic [IRQ_LEVELS-1:0] isr_q, isr_d;
  logic                  int_q, int_d;
  logic                  freeze_q, freeze_d;
  logic [IRQ_LEVELS-1:0] clear_q, clear_d;
  logic [7:0]            dataOut_q, dataOut_d;
  logic                  dataOutEn_q, dataOutEn_d;

  logic                  intaFall;
  logic                  intaRise;
  logic [2:0]            reqLevel;
  logic                  reqValid;
  logic [2:0]            eoiLevel;
  logic                  eoiValid;
  logic [IRQ_LEVELS-1:0] isrSet;
  logic [IRQ_LEVELS-1:0] isrAutoClear;
  logic [IRQ_LEVELS-1:0] isrEoiClear;

  assign intaFall = intaN_q & ~bus.interrupt_acknowledge_n;
  assign intaRise = ~intaN_q & bus.interrupt_acknowledge_n;

  priority_resolver_8259a u_requestResolver (
    .request_i    (bus.interrupt_request_register),
    .mask_i       (bus.interrupt_mask),
    .in_service_i (isr_q),
    .winner_o     (reqLevel),
    .valid_o      (reqValid)
  );

  // Same resolver used as a plain priority encoder to find the
  // highest-priority in-service level for a non-specific EOI.
  priority_resolver_8259a u_eoiResolver (
    .request_i    (isr_q),
    .mask_i       ('0),
    .in_service_i ('0),
    .winner_o     (eoiLevel),
    .valid_o      (eoiValid)
  );

  // State and output registers; reset drops everything back to IDLE with
  // the bus released and nothing in service.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      intaN_q     <= 1'b1;
      level_q     <= 3'd0;
      spurious_q  <= 1'b0;
      isr_q       <= '0;
      int_q       <= 1'b0;
      freeze_q    <= 1'b0;
      clear_q     <= '0;
      dataOut_q   <= '0;
      dataOutEn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      intaN_q     <= bus.interrupt_acknowledge_n;
      level_q     <= level_d;
      spurious_q  <= spurious_d;
      isr_q       <= isr_d;
      int_q       <= int_d;
      freeze_q    <= freeze_d;
      clear_q     <= clear_d;
      dataOut_q   <= dataOut_d;
      dataOutEn_q <= dataOutEn_d;
    end
  end

  // Handshake sequencing. INTA edges that arrive in a state not waiting for
  // them simply fall through the case arms. The ISR update merges the
  // acknowledge set with the EOI/auto-EOI clears, so an EOI coinciding with
  // the first INTA edge acts on the ISR as it was before the new bit.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    spurious_d   = spurious_q;
    int_d        = int_q;
    freeze_d     = freeze_q;
    clear_d      = '0;
    dataOut_d    = dataOut_q;
    dataOutEn_d  = dataOutEn_q;
    isrSet       = '0;
    isrAutoClear = '0;
    isrEoiClear  = '0;

    case (state_q)
      IDLE: begin
        if (reqValid) begin
          state_d = REQUEST;
          int_d   = 1'b1;
        end
      end
      REQUEST: begin
        if (intaFall) begin
          int_d    = 1'b0;
          freeze_d = 1'b1;
          state_d  = ACK1;
          if (reqValid) begin
            level_d    = reqLevel;
            spurious_d = 1'b0;
            isrSet     = IRQ_LEVELS'(1) << reqLevel;
            clear_d    = IRQ_LEVELS'(1) << reqLevel;
          end else begin
            level_d    = SPURIOUS_LEVEL;
            spurious_d = 1'b1;
          end
        end
      end
      ACK1: begin
        dataOutEn_d = 1'b0;
        if (intaRise) begin
          state_d = WAIT2;
        end
      end
      WAIT2: begin
        if (intaFall) begin
          state_d     = ACK2;
          dataOut_d   = {bus.vector_base, level_q};
          dataOutEn_d = 1'b1;
        end
      end
      ACK2: begin
        if (intaRise) begin
          state_d     = IDLE;
          dataOutEn_d = 1'b0;
          freeze_d    = 1'b0;
          if (AutoEoi && !spurious_q) begin
            isrAutoClear = IRQ_LEVELS'(1) << level_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.end_of_interrupt && eoiValid) begin
      isrEoiClear = IRQ_LEVELS'(1) << eoiLevel;
    end

    isr_d = (isr_q & ~isrEoiClear & ~isrAutoClear) | isrSet;
  end

  assign bus.interrupt_to_cpu        = int_q;
  assign bus.freeze                  = freeze_q;
  assign bus.clear_interrupt_request = clear_q;
  assign bus.in_service_register     = isr_q;
  assign bus.data_out                = dataOut_q;
  assign bus.data_out_enable         = dataOutEn_q;

endmodule

// File: doc/interrupt_ack_sequencer_8259a.md
Name: interrupt_ack_sequencer_8259a

Overview:
Consumer side of the 8259A interrupt request register. It resolves priority over the captured requests and the mask, raises INT to the CPU, and runs the two-pulse INTA handshake (8086 mode). It maintains the in-service register, pulses clear_interrupt_request back into the request register, and drives freeze into it while an acknowledge is in progress. It also drives the interrupt vector onto the data bus during the second INTA pulse.

Parameters:
SPURIOUS_LEVEL, 3'd7, level reported when no eligible request exists at the first INTA falling edge.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
interrupt_request_register  in  8  IRR from request block; bit0 = IR0
interrupt_mask  in  8  1 = level masked
vector_base  in  5  T7..T3 from ICW2
interrupt_acknowledge_n  in  1  INTA#, already synchronous to clock
end_of_interrupt  in  1  one-cycle non-specific EOI pulse
interrupt_to_cpu  out  1  INT
freeze  out  1  holds the request register during acknowledge
clear_interrupt_request  out  8  one-hot, one-cycle pulse clearing the acknowledged IRR bit
in_service_register  out  8  ISR
data_out  out  8  vector byte
data_out_enable  out  1  drive enable for data_out

Behaviour:
- Reset: all outputs 0; ISR = 0; state IDLE; registered inta_n_q = 1.
- Edge detection:
  - Falling edge = inta_n_q & ~interrupt_acknowledge_n.
  - Rising edge = ~inta_n_q & interrupt_acknowledge_n.
  - inta_n_q is registered every clock.
- Eligibility is fixed priority, fully nested; IR0 is highest.
  - eligible = IRR & ~interrupt_mask, restricted to levels strictly higher in priority than the highest set ISR bit.
  - The winner is the lowest-index eligible bit.
- States and transitions:
  - IDLE: any eligible bit moves to REQUEST; interrupt_to_cpu = 1 from the next cycle.
  - REQUEST: INT stays high even if the request drops.
    - On a falling edge, latch the winner level.
    - If there is no winner: latch SPURIOUS_LEVEL and a spurious flag; ISR and IRR are untouched.
    - Otherwise: set the ISR bit, and pulse clear_interrupt_request for exactly one cycle.
    - In both cases: INT goes to 0 and freeze goes to 1 in the same cycle; go to ACK1.
  - ACK1: data_out_enable = 0; a rising edge moves to WAIT2.
  - WAIT2: a falling edge moves to ACK2.
  - ACK2: data_out = {vector_base, level} and data_out_enable = 1 while in ACK2.
    - A rising edge clears data_out_enable and freeze, and moves to IDLE.
    - A new eligible request re-enters REQUEST one cycle later via IDLE.
- INTA edges in an unexpected state (IDLE, or a rising edge in REQUEST) are ignored.
- EOI (any state): clears the highest-priority set ISR bit; no effect if ISR = 0.
  - If EOI coincides with the ISR set in REQUEST, EOI acts on the pre-set ISR value and both updates apply.
- Latency: IRR bit to INT = 1 clock from IDLE. Vector is valid the first clock after the ACK2 falling edge is detected.
- Reset mid-handshake: immediate return to IDLE; freeze = 0, data_out_enable = 0, ISR cleared.
- data_out holds its last value when not enabled; its value matters only when data_out_enable = 1.

Optional Feature:
AUTO_EOI_EN
- Defined: on the ACK2 rising edge, the ISR bit set by this acknowledge is cleared in the same cycle as the return to IDLE. A spurious acknowledge changes nothing.
- Not defined: ISR bits clear only via end_of_interrupt.

Decomposition:
- Package pic_8259a_pkg: state enum (IDLE, REQUEST, ACK1, WAIT2, ACK2); IRQ_LEVELS = 8; a function returning the lowest set bit index plus a valid flag; a function for a one-hot mask of levels above a given priority.
- One sub-module, priority_resolver_8259a: combinational winner and valid output from IRR, mask and ISR. It is reused for the EOI highest-ISR lookup with the mask and ISR inputs tied to 0.

Test Plan:
- IRR = 0x04, mask = 0, vector_base = 5'h08: INT rises 1 clock later. First INTA: ISR = 0x04, clear_interrupt_request = 0x04 for one cycle, freeze = 1. Second INTA: data_out = 0x42 with enable. freeze = 0 after the rising edge.
- IRR = 0x81, mask = 0x01: IR7 wins, ISR = 0x80, vector low bits = 3'b111. Then EOI: ISR = 0x00.
- Nesting: ISR = 0x08 (IR3 in service), IRR = 0x10: no INT. Change IRR to 0x02: INT asserts and ISR becomes 0x0A. EOI clears bit1 (ISR = 0x08).
- Spurious: IRR = 0x02 raises INT, then IRR drops to 0 before INTA: data_out low bits = 3'b111, ISR unchanged, no clear pulse.
- Reset asserted in ACK1: all outputs 0 on the next sample, ISR = 0, state IDLE. An INTA pulse afterwards produces no response.
- AUTO_EOI_EN build: the IR5 handshake leaves ISR = 0x00 after the second INTA rising edge. Without the macro, ISR = 0x20 remains.
